fetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter register.
- Reads the current PC, issues a req/ready fetch to instruction memory, and latches the returned word into an instruction register (IR).
- Presents the IR to decode over a valid/ready handshake.
- Computes the next PC (sequential or branch redirect) and drives the PC register's load-enable and data inputs.
- Multi-cycle design: one instruction in flight at a time.

---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: PC register, instruction memory, decode and redirect signals.
// Mapping of modports to sides of the bus:
//   master = fetch unit side, slave = environment side.
interface fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            update_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] ir;
    logic            ir_valid;
    logic            decode_ready;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            fetch_error;

    modport master (
        input  pc, imem_ready, imem_rdata, decode_ready, branch_taken, branch_target,
        output pc_next, update_pc, imem_req, imem_addr, ir, ir_valid, fetch_error
    );

    modport slave (
        output pc, imem_ready, imem_rdata, decode_ready, branch_taken, branch_target,
        input  pc_next, update_pc, imem_req, imem_addr, ir, ir_valid, fetch_error
    );
endinterface

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch: one request in flight, IR delivered to decode,
// next PC (sequential or redirect) pushed back to the PC register.
module fetch_unit #(
    parameter int unsigned PC_STEP = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_START   = 3'd0,
        S_WAIT    = 3'd1,
        S_DELIVER = 3'd2,
        S_PCWAIT  = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_imem_req,         w_imem_req_nxt;
    logic [XLEN-1:0] r_imem_addr,        w_imem_addr_nxt;
    logic [XLEN-1:0] r_ir,               w_ir_nxt;
    logic            r_ir_valid,         w_ir_valid_nxt;
    logic            r_update_pc,        w_update_pc_nxt;
    logic [XLEN-1:0] r_pc_next,          w_pc_next_nxt;
    logic            r_fetch_error,      w_fetch_error_nxt;
    logic            r_redirect_pending, w_redirect_pending_nxt;
    logic [XLEN-1:0] r_redirect_target,  w_redirect_target_nxt;
    logic [CNT_W-1:0] r_wait_cnt,        w_wait_cnt_nxt;

    logic            w_redirect;
    logic            w_timeout;
    logic [XLEN-1:0] w_seq_pc;

    assign w_redirect = r_redirect_pending | bus.branch_taken;
    assign w_timeout  = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
    assign w_seq_pc   = bus.pc + XLEN'(PC_STEP);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_START;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_START:   w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.imem_ready) w_state_nxt = w_redirect ? S_PCWAIT : S_DELIVER;
                else if (w_timeout) w_state_nxt = S_ERROR;
            end
            S_DELIVER: if (bus.decode_ready) w_state_nxt = S_PCWAIT;
            S_PCWAIT:  w_state_nxt = S_START;
            S_ERROR:   w_state_nxt = S_ERROR;
            default:   w_state_nxt = S_START;
        endcase
    end

    // Next values of the registered outputs and datapath state
    always_comb begin
        w_imem_req_nxt         = r_imem_req;
        w_imem_addr_nxt        = r_imem_addr;
        w_ir_nxt               = r_ir;
        w_ir_valid_nxt         = r_ir_valid;
        w_update_pc_nxt        = 1'b0;
        w_pc_next_nxt          = r_pc_next;
        w_fetch_error_nxt      = r_fetch_error;
        w_redirect_pending_nxt = r_redirect_pending;
        w_redirect_target_nxt  = r_redirect_target;
        w_wait_cnt_nxt         = r_wait_cnt;

        // A redirect not consumed this cycle is remembered; last one wins
        if (bus.branch_taken && r_state != S_ERROR) begin
            w_redirect_pending_nxt = 1'b1;
            w_redirect_target_nxt  = bus.branch_target;
        end

        case (r_state)
            S_START: begin
                w_imem_req_nxt  = 1'b1;
                w_imem_addr_nxt = bus.pc;
                w_wait_cnt_nxt  = '0;
            end
            S_WAIT: begin
                if (bus.imem_ready) begin
                    w_imem_req_nxt = 1'b0;
                    if (w_redirect) begin
                        w_pc_next_nxt          = bus.branch_taken ? bus.branch_target
                                                                  : r_redirect_target;
                        w_redirect_pending_nxt = 1'b0;
                        w_update_pc_nxt        = 1'b1;
                    end else begin
                        w_ir_nxt       = bus.imem_rdata;
                        w_ir_valid_nxt = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_imem_req_nxt    = 1'b0;
                    w_fetch_error_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            S_DELIVER: begin
                if (bus.decode_ready) begin
                    w_ir_valid_nxt         = 1'b0;
                    w_update_pc_nxt        = 1'b1;
                    w_redirect_pending_nxt = 1'b0;
                    if (bus.branch_taken)         w_pc_next_nxt = bus.branch_target;
                    else if (r_redirect_pending)  w_pc_next_nxt = r_redirect_target;
                    else                          w_pc_next_nxt = w_seq_pc;
                end
            end
            S_ERROR: begin
                w_imem_req_nxt = 1'b0;
                w_ir_valid_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_imem_req         <= 1'b0;
            r_imem_addr        <= '0;
            r_ir               <= '0;
            r_ir_valid         <= 1'b0;
            r_update_pc        <= 1'b0;
            r_pc_next          <= '0;
            r_fetch_error      <= 1'b0;
            r_redirect_pending <= 1'b0;
            r_redirect_target  <= '0;
            r_wait_cnt         <= '0;
        end else begin
            r_imem_req         <= w_imem_req_nxt;
            r_imem_addr        <= w_imem_addr_nxt;
            r_ir               <= w_ir_nxt;
            r_ir_valid         <= w_ir_valid_nxt;
            r_update_pc        <= w_update_pc_nxt;
            r_pc_next          <= w_pc_next_nxt;
            r_fetch_error      <= w_fetch_error_nxt;
            r_redirect_pending <= w_redirect_pending_nxt;
            r_redirect_target  <= w_redirect_target_nxt;
            r_wait_cnt         <= w_wait_cnt_nxt;
        end
    end

    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_imem_addr;
    assign bus.ir          = r_ir;
    assign bus.ir_valid    = r_ir_valid;
    assign bus.update_pc   = r_update_pc;
    assign bus.pc_next     = r_pc_next;
    assign bus.fetch_error = r_fetch_error;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural PC register.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_reg;
    logic        pc_force;
    logic [31:0] pc_force_val;
    int          n_tests = 0;
    int          n_fail  = 0;

    fetch_unit_if bus();

    fetch_unit #(.PC_STEP(4), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // PC register: loads pc_next on update_pc, or a bench-forced value
    always @(posedge clk) begin
        if (pc_force)           pc_reg <= pc_force_val;
        else if (bus.update_pc) pc_reg <= bus.pc_next;
    end
    assign bus.pc = pc_reg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        reset             = 1'b1;
        pc_force          = 1'b1;
        pc_force_val      = start_pc;
        bus.imem_ready    = 1'b0;
        bus.imem_rdata    = '0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.decode_ready  = 1'b1;
        step();
        step();
        reset    = 1'b0;
        pc_force = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},     32'(bus.imem_req),    32'h0);
        check({tag, "_addr"},    bus.imem_addr,        32'h0);
        check({tag, "_ir"},      bus.ir,               32'h0);
        check({tag, "_irv"},     32'(bus.ir_valid),    32'h0);
        check({tag, "_upd"},     32'(bus.update_pc),   32'h0);
        check({tag, "_pcnext"},  bus.pc_next,          32'h0);
        check({tag, "_err"},     32'(bus.fetch_error), 32'h0);
    endtask

    initial begin
        // Reset state and basic single-cycle fetch from pc=0
        do_reset(32'h0);
        check_reset_outputs("rst");
        step();
        check("t1_req",  32'(bus.imem_req), 32'h1);
        check("t1_addr", bus.imem_addr,     32'h0);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0000_0013;
        step();
        check("t1_irv",  32'(bus.ir_valid), 32'h1);
        check("t1_ir",   bus.ir,            32'h0000_0013);
        check("t1_req0", 32'(bus.imem_req), 32'h0);
        bus.imem_ready = 1'b0;
        step();
        check("t1_irv0", 32'(bus.ir_valid),  32'h0);
        check("t1_upd",  32'(bus.update_pc), 32'h1);
        check("t1_pcn",  bus.pc_next,        32'h4);
        step();
        check("t1_upd0", 32'(bus.update_pc), 32'h0);
        step();
        check("t1_req2",  32'(bus.imem_req), 32'h1);
        check("t1_addr2", bus.imem_addr,     32'h4);

        // Memory delayed 5 cycles at 0x40, then decode stalls
        do_reset(32'h40);
        step();
        check("t2_req", 32'(bus.imem_req), 32'h1);
        check("t2_addr", bus.imem_addr,    32'h40);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_req_hold",  32'(bus.imem_req),    32'h1);
            check("t2_addr_hold", bus.imem_addr,        32'h40);
            check("t2_irv_low",   32'(bus.ir_valid),    32'h0);
            check("t2_err_low",   32'(bus.fetch_error), 32'h0);
        end
        bus.imem_ready   = 1'b1;
        bus.imem_rdata   = 32'hDEAD_BEEF;
        bus.decode_ready = 1'b0;
        step();
        bus.imem_ready = 1'b0;
        check("t2_irv", 32'(bus.ir_valid), 32'h1);
        check("t2_ir",  bus.ir,            32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_irv_hold", 32'(bus.ir_valid),  32'h1);
            check("t3_ir_hold",  bus.ir,             32'hDEAD_BEEF);
            check("t3_upd_low",  32'(bus.update_pc), 32'h0);
            check("t3_req_low",  32'(bus.imem_req),  32'h0);
        end
        bus.decode_ready = 1'b1;
        step();
        check("t3_irv0", 32'(bus.ir_valid),  32'h0);
        check("t3_upd",  32'(bus.update_pc), 32'h1);
        check("t3_pcn",  bus.pc_next,        32'h44);

        // Branch pulsed during WAIT discards the fetched word
        step();
        step();
        check("t4_addr", bus.imem_addr, 32'h44);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h100;
        step();
        bus.branch_taken = 1'b0;
        bus.imem_ready   = 1'b1;
        bus.imem_rdata   = 32'h1111_1111;
        step();
        bus.imem_ready = 1'b0;
        check("t4_irv0", 32'(bus.ir_valid),  32'h0);
        check("t4_ir",   bus.ir,             32'hDEAD_BEEF);
        check("t4_req0", 32'(bus.imem_req),  32'h0);
        check("t4_upd",  32'(bus.update_pc), 32'h1);
        check("t4_pcn",  bus.pc_next,        32'h100);
        step();
        step();
        check("t4_req2",  32'(bus.imem_req), 32'h1);
        check("t4_addr2", bus.imem_addr,     32'h100);

        // Sequential PC wraps modulo 2^32
        do_reset(32'hFFFF_FFFC);
        step();
        check("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0000_0013;
        step();
        bus.imem_ready = 1'b0;
        check("t5_irv", 32'(bus.ir_valid), 32'h1);
        step();
        check("t5_upd", 32'(bus.update_pc), 32'h1);
        check("t5_pcn", bus.pc_next,        32'h0);

        // Memory never answers: sticky error after 16 WAIT cycles
        do_reset(32'h200);
        step();
        for (int i = 0; i < 15; i++) begin
            step();
            check("t6_err_low", 32'(bus.fetch_error), 32'h0);
            check("t6_req_hi",  32'(bus.imem_req),    32'h1);
        end
        step();
        check("t6_err", 32'(bus.fetch_error), 32'h1);
        check("t6_req0", 32'(bus.imem_req),   32'h0);
        bus.imem_ready    = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h500;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_err_sticky", 32'(bus.fetch_error), 32'h1);
            check("t6_req_off",    32'(bus.imem_req),    32'h0);
            check("t6_irv_off",    32'(bus.ir_valid),    32'h0);
            check("t6_upd_off",    32'(bus.update_pc),   32'h0);
        end
        bus.imem_ready   = 1'b0;
        bus.branch_taken = 1'b0;

        // Reset asserted mid-WAIT returns everything to reset values
        do_reset(32'h300);
        check("t7_err_clr", 32'(bus.fetch_error), 32'h0);
        step();
        check("t7_req",  32'(bus.imem_req), 32'h1);
        check("t7_addr", bus.imem_addr,     32'h300);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_outputs("t7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
